// File: rtl/pwm_seq_ctrl.sv
// Compare-value sequencer feeding pwm_gen: steps a (compare1, compare2) table once per
// counter period for a programmed loop count, passing register-file values through when idle.
module pwm_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tbl_we,
    input  logic [AW-1:0]   tbl_addr,
    input  logic [2*W-1:0]  tbl_wdata,
    input  logic [AW:0]     seq_len,
    input  logic [7:0]      loops,
    input  logic            start,
    input  logic            stop,
    input  logic            counter_en,
    input  logic            upnotdown,
    input  logic [W-1:0]    period,
    input  logic [W-1:0]    counter_val,
    input  logic [W-1:0]    cmp1_byp,
    input  logic [W-1:0]    cmp2_byp,
    output logic [W-1:0]    compare1,
    output logic [W-1:0]    compare2,
    output logic            busy,
    output logic [AW-1:0]   step_idx,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [7:0]      loop_cnt_q, loop_cnt_d;
    logic [W-1:0]    prev_val_q;
    logic            stop_pend_q, stop_pend_d;
    logic [W-1:0]    cmp1_q, cmp1_d;
    logic [W-1:0]    cmp2_q, cmp2_d;
    logic            done_q, done_d;

    logic [2*W-1:0]  tbl_mem [DEPTH];
    logic [AW-1:0]   rd_addr;
    logic [2*W-1:0]  rd_data;
    logic            bnd;
    logic            seq_ok;
    logic            more_steps;
    logic            more_loops;

    // Table is deliberately left out of reset so contents survive a soft restart.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_mem[tbl_addr] <= tbl_wdata;
        end
    end

    assign rd_data = tbl_mem[rd_addr];

    // The value-change term gives one boundary per period even when the prescaler
    // holds the counter on its wrap value for several clocks.
    assign bnd = counter_en && (counter_val != prev_val_q) &&
                 ((upnotdown && (counter_val == '0)) || (!upnotdown && (counter_val == period)));

    assign seq_ok     = (seq_len != '0) && (seq_len <= (AW+1)'(DEPTH));
    assign more_steps = ((AW+1)'(idx_q) + (AW+1)'(1)) < seq_len;
    assign more_loops = (loops == 8'd0) || ((9'(loop_cnt_q) + 9'd1) < 9'(loops));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        loop_cnt_d  = loop_cnt_q;
        stop_pend_d = stop_pend_q;
        cmp1_d      = cmp1_q;
        cmp2_d      = cmp2_q;
        done_d      = 1'b0;
        rd_addr     = '0;
        case (state_q)
            S_IDLE: begin
                cmp1_d = cmp1_byp;
                cmp2_d = cmp2_byp;
                if (start && seq_ok) begin
                    state_d     = S_ARM;
                    idx_d       = '0;
                    loop_cnt_d  = '0;
                    stop_pend_d = stop;
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d     = S_IDLE;
                    stop_pend_d = 1'b0;
                end else if (bnd) begin
                    rd_addr = '0;
                    cmp1_d  = rd_data[2*W-1:W];
                    cmp2_d  = rd_data[W-1:0];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bnd) begin
                    if (stop_pend_q) begin
                        state_d     = S_IDLE;
                        cmp1_d      = cmp1_byp;
                        cmp2_d      = cmp2_byp;
                        stop_pend_d = 1'b0;
                    end else if (more_steps) begin
                        idx_d       = idx_q + AW'(1);
                        rd_addr     = idx_q + AW'(1);
                        cmp1_d      = rd_data[2*W-1:W];
                        cmp2_d      = rd_data[W-1:0];
                        stop_pend_d = stop;
                    end else if (more_loops) begin
                        idx_d       = '0;
                        loop_cnt_d  = (loop_cnt_q == 8'hFF) ? loop_cnt_q : loop_cnt_q + 8'd1;
                        rd_addr     = '0;
                        cmp1_d      = rd_data[2*W-1:W];
                        cmp2_d      = rd_data[W-1:0];
                        stop_pend_d = stop;
                    end else begin
                        state_d     = S_IDLE;
                        cmp1_d      = cmp1_byp;
                        cmp2_d      = cmp2_byp;
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            loop_cnt_q  <= '0;
            prev_val_q  <= '0;
            stop_pend_q <= 1'b0;
            cmp1_q      <= '0;
            cmp2_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            loop_cnt_q  <= loop_cnt_d;
            prev_val_q  <= counter_val;
            stop_pend_q <= stop_pend_d;
            cmp1_q      <= cmp1_d;
            cmp2_q      <= cmp2_d;
            done_q      <= done_d;
        end
    end

    assign compare1 = cmp1_q;
    assign compare2 = cmp2_q;
    assign busy     = (state_q != S_IDLE);
    assign step_idx = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: a counter driver pushes hand-computed per-boundary expectations
// into a queue, and a negedge monitor pops and compares them, plus checks hold between boundaries.
module tb_pwm_seq_ctrl;
    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int EW    = 2*W + 2 + AW;

    logic            clk;
    logic            rst_n;
    logic            tbl_we;
    logic [AW-1:0]   tbl_addr;
    logic [2*W-1:0]  tbl_wdata;
    logic [AW:0]     seq_len;
    logic [7:0]      loops;
    logic            start;
    logic            stop;
    logic            counter_en;
    logic            upnotdown;
    logic [W-1:0]    period;
    logic [W-1:0]    counter_val;
    logic [W-1:0]    cmp1_byp;
    logic [W-1:0]    cmp2_byp;
    logic [W-1:0]    compare1;
    logic [W-1:0]    compare2;
    logic            busy;
    logic [AW-1:0]   step_idx;
    logic            done;

    pwm_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_wdata   (tbl_wdata),
        .seq_len     (seq_len),
        .loops       (loops),
        .start       (start),
        .stop        (stop),
        .counter_en  (counter_en),
        .upnotdown   (upnotdown),
        .period      (period),
        .counter_val (counter_val),
        .cmp1_byp    (cmp1_byp),
        .cmp2_byp    (cmp2_byp),
        .compare1    (compare1),
        .compare2    (compare2),
        .busy        (busy),
        .step_idx    (step_idx),
        .done        (done)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            cyc_q[$];
    int            tag_q[$];
    logic [EW-1:0] plan_q[$];

    int            n_checks = 0;
    int            n_errors = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    int            cur_tag  = 0;
    int            bnd_seen = 0;
    int            prescale = 0;
    int            hold_cnt = 0;
    logic          hold_en  = 1'b0;
    logic          end_req  = 1'b0;
    logic          end_ack  = 1'b0;
    logic [EW-1:0] cur_hold = '0;
    logic [EW-1:0] got_v;
    logic [EW-1:0] pop_v;
    int            pop_tag;

    logic [W-1:0]  byp1, byp2;
    logic [W-1:0]  t1 [3];
    logic [W-1:0]  t2 [3];

    function automatic logic [EW-1:0] pack(input logic [W-1:0] c1, input logic [W-1:0] c2,
                                           input logic b, input logic d, input logic [AW-1:0] ix);
        return {c1, c2, b, d, ix};
    endfunction

    function automatic logic [EW-1:0] entry(input int i, input logic [AW-1:0] ix);
        return pack(t1[i], t2[i], 1'b1, 1'b0, ix);
    endfunction

    task automatic check_vec(input string name, input int tag, input logic [EW-1:0] got,
                             input logic [EW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s tag=%0d cyc=%0d got c1=%02h c2=%02h busy=%b done=%b idx=%0d want c1=%02h c2=%02h busy=%b done=%b idx=%0d",
                     name, tag, cyc, got[EW-1:EW-W], got[EW-W-1:AW+2], got[AW+1], got[AW], got[AW-1:0],
                     want[EW-1:EW-W], want[EW-W-1:AW+2], want[AW+1], want[AW], want[AW-1:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        got_v = {compare1, compare2, busy, done, step_idx};
        if (done === 1'b1) done_cnt++;
        while (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
            pop_v   = exp_q.pop_front();
            pop_tag = tag_q.pop_front();
            void'(cyc_q.pop_front());
            check_vec("stale_expectation", pop_tag, got_v, ~pop_v);
        end
        if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
            pop_v   = exp_q.pop_front();
            pop_tag = tag_q.pop_front();
            void'(cyc_q.pop_front());
            check_vec("step", pop_tag, got_v, pop_v);
            cur_hold     = pop_v;
            cur_hold[AW] = 1'b0;
        end else if (hold_en) begin
            check_vec("hold", cur_tag, got_v, cur_hold);
        end
        if (end_req && !end_ack) begin
            check_int("pending_expectations", exp_q.size() + plan_q.size(), 0);
            check_int("done_pulses", done_cnt, exp_done);
            end_ack = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_at(input logic [EW-1:0] v, input int c);
        exp_q.push_back(v);
        cyc_q.push_back(c);
        tag_q.push_back(cur_tag);
    endtask

    task automatic push_now(input logic [EW-1:0] v);
        push_at(v, cyc);
    endtask

    // One clock: advance the modelled counter and schedule the planned response to a boundary.
    task automatic clk_step();
        @(posedge clk);
        #1;
        if (counter_en) begin
            if (hold_cnt == prescale) begin
                hold_cnt = 0;
                if (upnotdown) counter_val = (counter_val == period) ? '0 : counter_val + 1'b1;
                else           counter_val = (counter_val == '0) ? period : counter_val - 1'b1;
                if ((upnotdown && counter_val == '0) || (!upnotdown && counter_val == period)) begin
                    bnd_seen++;
                    if (plan_q.size() > 0) push_at(plan_q.pop_front(), cyc + 1);
                end
            end else begin
                hold_cnt++;
            end
        end
    endtask

    task automatic run_until(input int target, input int bound);
        for (int i = 0; i < bound && bnd_seen < target; i++) clk_step();
    endtask

    task automatic write_tbl(input logic [AW-1:0] a, input logic [W-1:0] c1, input logic [W-1:0] c2);
        tbl_we    = 1'b1;
        tbl_addr  = a;
        tbl_wdata = {c1, c2};
        clk_step();
        tbl_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        clk_step();
        start = 1'b0;
    endtask

    task automatic setup_counter(input logic up, input logic [W-1:0] per, input int ps,
                                 input logic [W-1:0] init_val);
        counter_en  = 1'b0;
        upnotdown   = up;
        period      = per;
        prescale    = ps;
        hold_cnt    = 0;
        counter_val = init_val;
        bnd_seen    = 0;
        clk_step();
    endtask

    task automatic plan_finite(input logic [AW-1:0] last_idx, input int n_loops);
        for (int l = 0; l < n_loops; l++)
            for (int i = 0; i < 3; i++) plan_q.push_back(entry(i, AW'(i)));
        plan_q.push_back(pack(byp1, byp2, 1'b0, 1'b1, last_idx));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        t1[0] = 8'd10; t2[0] = 8'd50;
        t1[1] = 8'd20; t2[1] = 8'd60;
        t1[2] = 8'd30; t2[2] = 8'd70;
        byp1 = 8'h20; byp2 = 8'h40;
        rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        seq_len = '0; loops = '0; start = 1'b0; stop = 1'b0;
        counter_en = 1'b0; upnotdown = 1'b1; period = 8'd99; counter_val = '0;
        cmp1_byp = byp1; cmp2_byp = byp2;

        // 1: reset values, then bypass one cycle after release
        cur_tag = 1;
        repeat (3) clk_step();
        push_now(pack(8'h00, 8'h00, 1'b0, 1'b0, 4'd0));
        hold_en = 1'b1;
        clk_step();
        rst_n = 1'b1;
        clk_step();
        push_now(pack(byp1, byp2, 1'b0, 1'b0, 4'd0));
        for (int i = 0; i < 3; i++) write_tbl(AW'(i), t1[i], t2[i]);

        // 2: up-count, no prescale, 3 entries x 2 loops then done
        cur_tag = 2;
        setup_counter(1'b1, 8'd99, 0, 8'd50);
        seq_len = 5'd3; loops = 8'd2;
        pulse_start();
        push_now(pack(byp1, byp2, 1'b1, 1'b0, 4'd0));
        plan_finite(4'd2, 2);
        exp_done++;
        counter_en = 1'b1;
        run_until(7, 2000);
        repeat (5) clk_step();

        // 3: prescale holds each value 4 clocks; still one step per period
        cur_tag = 3;
        setup_counter(1'b1, 8'd19, 3, 8'd5);
        pulse_start();
        push_now(pack(byp1, byp2, 1'b1, 1'b0, 4'd0));
        plan_finite(4'd2, 2);
        exp_done++;
        counter_en = 1'b1;
        run_until(7, 3000);
        repeat (5) clk_step();

        // 4: down-count, run forever past loop-count saturation, then stop mid-period
        cur_tag = 4;
        setup_counter(1'b0, 8'd9, 0, 8'd5);
        seq_len = 5'd2; loops = 8'd0;
        pulse_start();
        push_now(pack(byp1, byp2, 1'b1, 1'b0, 4'd0));
        for (int k = 0; k < 600; k++) plan_q.push_back(entry(k % 2, AW'(k % 2)));
        counter_en = 1'b1;
        run_until(600, 7000);
        plan_q.push_back(pack(byp1, byp2, 1'b0, 1'b0, 4'd1));
        repeat (3) clk_step();
        stop = 1'b1;
        clk_step();
        stop = 1'b0;
        run_until(601, 50);
        repeat (5) clk_step();
        counter_en = 1'b0;

        // 5: invalid seq_len ignored; stop while armed returns to idle without done
        cur_tag = 5;
        clk_step();
        seq_len = 5'd0;
        pulse_start();
        push_now(pack(byp1, byp2, 1'b0, 1'b0, 4'd1));
        seq_len = 5'd17;
        pulse_start();
        push_now(pack(byp1, byp2, 1'b0, 1'b0, 4'd1));
        seq_len = 5'd2;
        pulse_start();
        push_now(pack(byp1, byp2, 1'b1, 1'b0, 4'd0));
        stop = 1'b1;
        clk_step();
        stop = 1'b0;
        push_now(pack(byp1, byp2, 1'b0, 1'b0, 4'd0));
        repeat (3) clk_step();

        // 6: async reset mid-run at idx 1, then table survives for a new run
        cur_tag = 6;
        setup_counter(1'b1, 8'd19, 0, 8'd3);
        seq_len = 5'd3; loops = 8'd0;
        pulse_start();
        push_now(pack(byp1, byp2, 1'b1, 1'b0, 4'd0));
        plan_q.push_back(entry(0, 4'd0));
        plan_q.push_back(entry(1, 4'd1));
        counter_en = 1'b1;
        run_until(2, 200);
        repeat (5) clk_step();
        rst_n = 1'b0;
        counter_en = 1'b0;
        byp1 = 8'h21; byp2 = 8'h41;
        cmp1_byp = byp1; cmp2_byp = byp2;
        push_now(pack(8'h00, 8'h00, 1'b0, 1'b0, 4'd0));
        repeat (3) clk_step();
        rst_n = 1'b1;
        clk_step();
        push_now(pack(byp1, byp2, 1'b0, 1'b0, 4'd0));
        setup_counter(1'b1, 8'd19, 0, 8'd3);
        loops = 8'd1;
        pulse_start();
        push_now(pack(byp1, byp2, 1'b1, 1'b0, 4'd0));
        plan_finite(4'd2, 1);
        exp_done++;
        counter_en = 1'b1;
        run_until(4, 500);
        repeat (5) clk_step();
        counter_en = 1'b0;

        // final report
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) clk_step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
Compare-value sequencer between the register file and pwm_gen. It holds a small table of (compare1, compare2) pairs and steps through it, one entry per counter period, for a programmed number of loops. Updates are applied only at period boundaries, so pwm_gen never sees a mid-period compare change. When idle, the block passes the register-file compare values straight through.

Parameters:
DEPTH, 16, number of table entries (power of two)
AW, 4, table address width, log2(DEPTH)
W, 8, width of the compare, period and counter values

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tbl_we  input  1  table write strobe, one cycle
tbl_addr  input  AW  table write address
tbl_wdata  input  2*W  [2W-1:W]=compare1, [W-1:0]=compare2
seq_len  input  AW+1  entries used, 1..DEPTH; 0 = invalid
loops  input  8  loop count; 0 = run forever
start  input  1  one-cycle start pulse
stop  input  1  one-cycle stop request
counter_en  input  1  counter enable, from regs
upnotdown  input  1  counter direction, from regs
period  input  W  counter period, from regs
counter_val  input  W  live counter value
cmp1_byp  input  W  register-file compare1, used when idle
cmp2_byp  input  W  register-file compare2, used when idle
compare1  output  W  compare1 to pwm_gen (registered)
compare2  output  W  compare2 to pwm_gen (registered)
busy  output  1  high in ARM or RUN
step_idx  output  AW  current table index
done  output  1  one-cycle pulse when a finite sequence completes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, idx=0, loop_cnt=0, prev_val=0, stop_pend=0.
  - compare1=0, compare2=0, busy=0, done=0.
  - Table contents are not reset.
- Table: synchronous write on tbl_we. A write is allowed in any state. A written entry takes effect the next time that entry is loaded.
- Boundary detection:
  - prev_val registers counter_val every cycle.
  - bnd = counter_en && (counter_val != prev_val) && ((upnotdown && counter_val==0) || (!upnotdown && counter_val==period)).
  - Because of the value-change qualifier, the prescaler can hold a value for many cycles and still yield exactly one bnd per period.
  - A soft reset that forces the counter to 0 while counting up counts as a boundary.
- Output timing: compare outputs change on the clock edge that ends the bnd cycle, so they are visible one cycle after counter_val reaches the boundary value.
- IDLE:
  - compare1/2 <= cmp1_byp/cmp2_byp every cycle; busy=0.
  - start with seq_len in 1..DEPTH -> ARM, idx=0, loop_cnt=0.
  - start with seq_len==0 or seq_len>DEPTH is ignored.
- ARM:
  - compare outputs hold their last value.
  - On bnd: load table[0], go to RUN.
  - stop in ARM returns to IDLE immediately; no done pulse.
- RUN, on bnd:
  - If stop_pend: go to IDLE, load the bypass values, clear stop_pend, no done pulse.
  - Else if idx < seq_len-1: idx++, load table[idx+1].
  - Else if loops==0 or loop_cnt+1 < loops: idx=0, loop_cnt++ (8-bit; saturates at 255 when loops==0), load table[0].
  - Else: go to IDLE, load the bypass values, pulse done for one cycle.
- stop in RUN sets stop_pend. The stop is acted on at the next bnd, never mid-period.
- Ignored inputs:
  - start while busy is ignored.
  - Changes to seq_len or loops during RUN take effect at the next bnd comparison. If a new seq_len <= idx, the next bnd ends the current loop.
- Simultaneous events:
  - start and stop in the same cycle while IDLE: start wins, and stop_pend is set.
  - bnd and stop in the same cycle in RUN: the current bnd still advances the sequence; the stop is acted on at the following bnd.
- counter_en=0: no bnd occurs, so the state and outputs freeze (bypass tracking still runs in IDLE).
- step_idx=idx in all states.

Test Plan:
- Reset, then IDLE with cmp1_byp=0x20, cmp2_byp=0x40 -> compare1=0x20, compare2=0x40 one cycle later, busy=0, done=0.
- Table {0:(10,50), 1:(20,60), 2:(30,70)}, seq_len=3, loops=2, period=99, upnotdown=1, prescale=0, start -> outputs follow entries 0,1,2,0,1,2, each loaded one cycle after counter_val=0. After the 6th period: done pulses once, outputs revert to the bypass values, busy=0.
- Same table with prescale=3 (value held 4 clocks) -> exactly one advance per period; idx never skips.
- Down-count, period=9, loops=0, seq_len=2 -> entries alternate on every reload to 9 indefinitely; done never pulses after more than 300 periods.
- stop pulse mid-period in RUN -> outputs unchanged until the next boundary, then bypass values, busy=0, no done. Also check: start with seq_len=0 leaves the block in IDLE.
- rst_n asserted mid-RUN at idx=1 -> outputs 0 immediately (asynchronously). After release: IDLE, bypass values tracked, and table contents preserved on the next start.
